// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, fetches from a variable-latency memory, computes next PC.
// Optional macro FETCH_PERF_EN adds a 32-bit fetch_count of accepted instructions.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  op_code,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    input  logic        inst_accept,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic        fsm_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // Handshake: imem_addr is held while imem_req is high until the cycle imem_ack is seen;
    // inst/inst_pc/op_code are held while inst_valid is high until the cycle inst_accept is seen.
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] inst_nxt, inst_pc_nxt;
    logic [31:0] next_pc, branch_off, jump_tgt;
    logic        req_en;

    // req_en keeps imem_req low during reset and lets the first request issue
    // on the first clock edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            inst    <= 32'h0000_0000;
            inst_pc <= RESET_PC;
            req_en  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            inst    <= inst_nxt;
            inst_pc <= inst_pc_nxt;
            req_en  <= 1'b1;
        end
    end

    assign pc_plus4   = inst_pc + 32'd4;
    assign branch_off = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4[31:28], inst[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_tgt;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        imem_req    = 1'b0;
        inst_valid  = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = req_en;
                if (req_en && imem_ack) begin
                    inst_nxt    = imem_rdata;
                    inst_pc_nxt = pc;
                    state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                inst_valid = 1'b1;
                if (inst_accept) begin
                    pc_nxt    = next_pc;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign imem_addr = pc;
    assign op_code   = inst[31:26];
    assign fsm_state = state;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (state == S_HOLD && inst_accept) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
